// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: grants one requester at a time, drives the memory strobes,
// and returns completion (mfc), read data and a timeout flag to the winning port.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT    = 15,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd0,
  input  logic        wr0,
  input  logic [15:0] addr0,
  input  logic [15:0] wdata0,
  input  logic        rd1,
  input  logic        wr1,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata1,
  output logic        mfc0,
  output logic        mfc1,
  output logic [15:0] rdata,
  output logic        err,
  output logic [1:0]  grant,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;  // 1: port 1 was granted last
  logic        mfc0_q, mfc0_d;
  logic        mfc1_q, mfc1_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic req0, req1, pick1, timed_out;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    mfc0_d      = mfc0_q;
    mfc1_d      = mfc1_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    grant_d     = grant_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    req0        = rd0 | wr0;
    req1        = rd1 | wr1;
    pick1       = req1 && (!req0 || (!FIXED_PRIO && !last_q));
    timed_out   = (cnt_q == CntMax);

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d = StAccess;
          cnt_d   = '0;
          if (pick1) begin
            grant_d     = 2'b10;
            mem_addr_d  = addr1;
            mem_wdata_d = wdata1;
            mem_read_d  = rd1;
            mem_write_d = wr1 & ~rd1;
          end else begin
            grant_d     = 2'b01;
            mem_addr_d  = addr0;
            mem_wdata_d = wdata0;
            mem_read_d  = rd0;
            mem_write_d = wr0 & ~rd0;
          end
        end
      end
      StAccess: begin
        if (mem_ready || timed_out) begin
          state_d     = StDone;
          mfc0_d      = grant_q[0];
          mfc1_d      = grant_q[1];
          last_d      = grant_q[1];
          grant_d     = 2'b00;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          // Ready wins over a simultaneous timeout.
          err_d       = !mem_ready;
          if (mem_read_q) begin
            rdata_d = mem_ready ? mem_rdata : 16'hFFFF;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        mfc0_d  = 1'b0;
        mfc1_d  = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      mfc0_q      <= 1'b0;
      mfc1_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      grant_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      mfc0_q      <= mfc0_d;
      mfc1_q      <= mfc1_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      grant_q     <= grant_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign mfc0      = mfc0_q;
  assign mfc1      = mfc1_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign grant     = grant_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table of single transactions checked through a
// scoreboard, plus reset-abort and two-port contention sequences.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  logic        mfc0, mfc1, err, mem_read, mem_write;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic [1:0]  grant;

  logic        fp_mfc0, fp_mfc1, fp_err, fp_mem_read, fp_mem_write;
  logic [15:0] fp_rdata, fp_mem_addr, fp_mem_wdata;
  logic [1:0]  fp_grant;

  mem_bus_arbiter #(.TIMEOUT(15), .FIXED_PRIO(1'b0)) dut (
    .clock(clock), .reset(reset),
    .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .mfc0(mfc0), .mfc1(mfc1), .rdata(rdata), .err(err), .grant(grant),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_bus_arbiter #(.TIMEOUT(15), .FIXED_PRIO(1'b1)) dut_fp (
    .clock(clock), .reset(reset),
    .rd0(rd0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .rd1(rd1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .mfc0(fp_mfc0), .mfc1(fp_mfc1), .rdata(fp_rdata), .err(fp_err), .grant(fp_grant),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_read(fp_mem_read),
    .mem_write(fp_mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          port;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] memval;
    int          delay;        // ACCESS cycles before ready; -1 = never
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_strobes;
  } vec_t;

  typedef struct {
    int          port;
    logic        is_read;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          strobes;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_delay = -1;
  int   acc_cnt = 0;

  // Memory model: assert ready in the ACCESS cycle numbered ready_delay.
  always @(negedge clock) begin
    if (mem_read || mem_write) begin
      mem_ready = (acc_cnt == ready_delay);
      acc_cnt   = acc_cnt + 1;
    end else begin
      mem_ready = 1'b0;
      acc_cnt   = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drop_all();
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
  endtask

  task automatic drive(input int port, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] wd);
    if (port == 0) begin
      rd0 = rd; wr0 = wr; addr0 = a; wdata0 = wd;
    end else begin
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = wd;
    end
  endtask

  task automatic wait_mfc(input bit chk_latency);
    exp_t e;
    int   strobes = 0;
    bit   done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clock);
      check("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      if (cyc == 0 && chk_latency) check("strobe_latency", {31'd0, mem_read | mem_write}, 32'd1);
      if ((mem_read || mem_write) && sb.size() > 0) begin
        e = sb[0];
        strobes++;
        check("grant", {30'd0, grant}, (e.port == 0) ? 32'd1 : 32'd2);
        check("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
        check("mem_read", {31'd0, mem_read}, {31'd0, e.is_read});
        check("mem_write", {31'd0, mem_write}, {31'd0, !e.is_read});
        if (!e.is_read) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
      end
      if (mfc0 || mfc1) begin
        if (sb.size() == 0) begin
          check("unexpected_mfc", {30'd0, mfc0, mfc1}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("mfc_port", {30'd0, mfc1, mfc0}, (e.port == 0) ? 32'd1 : 32'd2);
          check("err", {31'd0, err}, {31'd0, e.err});
          check("rdata", {16'd0, rdata}, {16'd0, e.rdata});
          check("strobe_cycles", strobes, e.strobes);
          check("grant_done", {30'd0, grant}, 32'd0);
        end
        drop_all();
        done = 1'b1;
      end else begin
        check("err_without_mfc", {31'd0, err}, 32'd0);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL mfc_wait: got no mfc expected mfc within 60 cycles at %0t", $time);
      drop_all();
      sb.delete();
    end else begin
      @(negedge clock);
      check("mfc_one_cycle", {30'd0, mfc0, mfc1}, 32'd0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drop_all();
    sb.delete();
    ready_delay = -1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  vec_t        vecs[8];
  exp_t        ex;
  logic [1:0]  exp_rr[4];
  logic [1:0]  prev_g, prev_fg;
  int          n, nf;

  initial begin
    vecs[0] = '{0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF,  0, 16'hBEEF, 1'b0,  1};
    vecs[1] = '{1, 1'b0, 1'b1, 16'h0100, 16'h1234, 16'hAAAA,  2, 16'hBEEF, 1'b0,  3};
    vecs[2] = '{0, 1'b1, 1'b0, 16'h0011, 16'h0000, 16'h5555, -1, 16'hFFFF, 1'b1, 15};
    vecs[3] = '{0, 1'b1, 1'b1, 16'h0ABC, 16'h9999, 16'h5A5A,  1, 16'h5A5A, 1'b0,  2};
    vecs[4] = '{1, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'hC3C3,  0, 16'hC3C3, 1'b0,  1};
    vecs[5] = '{0, 1'b0, 1'b1, 16'h0300, 16'h0F0F, 16'h1111, 14, 16'hC3C3, 1'b0, 15};
    vecs[6] = '{1, 1'b0, 1'b1, 16'h0310, 16'hF0F0, 16'h2222, -1, 16'hC3C3, 1'b1, 15};
    vecs[7] = '{1, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'h7777, 14, 16'h7777, 1'b0, 15};

    // Outputs while held in reset.
    repeat (2) @(negedge clock);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_mfc", {30'd0, mfc0, mfc1}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      ready_delay = vecs[i].delay;
      mem_rdata   = vecs[i].memval;
      ex = '{vecs[i].port, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_strobes};
      sb.push_back(ex);
      drive(vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_mfc(1'b1);
    end

    // Short reset pulse in the middle of an access aborts it without mfc.
    ready_delay = -1;
    mem_rdata   = 16'h1111;
    drive(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    repeat (3) @(negedge clock);
    check("abort_pre_strobe", {31'd0, mem_read}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_strobe_async", {30'd0, mem_read, mem_write}, 32'd0);
    check("abort_grant_async", {30'd0, grant}, 32'd0);
    check("abort_rdata_async", {16'd0, rdata}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("abort_no_mfc", {30'd0, mfc0, mfc1}, 32'd0);
    check("abort_no_early_grant", {30'd0, grant}, 32'd0);
    ready_delay = 0;
    ex = '{0, 1'b1, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1};
    sb.push_back(ex);
    wait_mfc(1'b1);

    // Both ports hold read requests: round-robin alternates, fixed priority keeps port 0.
    do_reset();
    ready_delay = 0;
    mem_rdata   = 16'h2222;
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
    prev_g = 2'b00; prev_fg = 2'b00; n = 0; nf = 0;
    drive(0, 1'b1, 1'b0, 16'h0A00, 16'h0000);
    drive(1, 1'b1, 1'b0, 16'h0B00, 16'h0000);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      if (grant != 2'b00 && prev_g == 2'b00 && n < 4) begin
        check("rr_grant", {30'd0, grant}, {30'd0, exp_rr[n]});
        n++;
      end
      if (fp_grant != 2'b00 && prev_fg == 2'b00 && nf < 4) begin
        check("fp_grant", {30'd0, fp_grant}, 32'd1);
        nf++;
      end
      prev_g  = grant;
      prev_fg = fp_grant;
    end
    check("rr_grant_count", n, 4);
    check("fp_grant_count", nf, 4);
    drop_all();
    repeat (4) @(negedge clock);
    check("fp_rdata", {16'd0, fp_rdata}, 32'h2222);
    check("fp_mem_addr", {16'd0, fp_mem_addr}, 32'h0A00);
    check("fp_mem_wdata", {16'd0, fp_mem_wdata}, 32'd0);
    check("fp_idle", {27'd0, fp_mfc0, fp_mfc1, fp_err, fp_mem_read, fp_mem_write}, 32'd0);
    check("rr_rdata", {16'd0, rdata}, 32'h2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum ACCESS cycles to wait for mem_ready, legal range 1..255.
REQ-002 Parameter FIXED_PRIO, default 0: 0 = round-robin arbitration; 1 = port 0 always wins.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  system clock, rising edge active.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 rd0, wr0  in  1 each  port 0 (CPU controller) read/write request.
REQ-007 addr0, wdata0  in  16 each  port 0 address and write data.
REQ-008 rd1, wr1  in  1 each  port 1 (DMA/IO) read/write request.
REQ-009 addr1, wdata1  in  16 each  port 1 address and write data.
REQ-010 mfc0, mfc1  out  1 each  memory-function-complete pulse to each port.
REQ-011 rdata  out  16  read data returned to the completed port.
REQ-012 err  out  1  timeout flag, valid only together with an mfc pulse.
REQ-013 grant  out  2  one-hot owner of the bus (01 = port 0, 10 = port 1, 00 = idle).
REQ-014 mem_addr, mem_wdata  out  16 each  address and write data to memory.
REQ-015 mem_read, mem_write  out  1 each  memory strobes.
REQ-016 mem_rdata  in  16  memory read data.
REQ-017 mem_ready  in  1  memory completion, sampled on clock.

Function
REQ-018 All outputs shall be registered.
REQ-019 The FSM shall have three states: IDLE, ACCESS, DONE.
REQ-020 Port N is requesting when rdN or wrN is 1; if both are 1, the access shall be a read.
REQ-021 Arbitration in IDLE:
  - If exactly one port requests, it wins.
  - If both request and FIXED_PRIO = 1, port 0 wins.
  - If both request and FIXED_PRIO = 0, the port not granted last wins.
REQ-022 IDLE->ACCESS on any request, at the same edge:
  - latch the winner's address, wdata and direction into mem_addr/mem_wdata;
  - set grant;
  - assert mem_read or mem_write;
  - clear the timeout counter.
REQ-023 ACCESS exits:
  - mem_ready = 1 -> DONE; on a read, latch mem_rdata into rdata.
  - No mem_ready, counter = TIMEOUT-1 -> DONE with err = 1; rdata = 16'hFFFF on a timed-out read.
  - Otherwise stay in ACCESS and increment the counter.
REQ-024 mem_ready takes precedence over timeout in the same cycle.
REQ-025 mem_addr, mem_wdata and the strobes shall stay stable throughout ACCESS.
REQ-026 DONE:
  - mfcN = 1 for exactly one cycle, granted port only;
  - err held with it;
  - strobes = 0; grant = 00;
  - record last-granted port;
  - -> IDLE unconditionally.
REQ-027 rdata shall hold its value until the next completed read.
REQ-028 Requester handshake:
  - Hold rd/wr, addr and wdata stable until mfc is seen.
  - Drop rd/wr at the edge that ends the DONE cycle, so IDLE never re-grants a finished request.
REQ-029 Minimum latency: request first sampled in cycle c -> strobe high in c+1 -> (mem_ready in c+1) -> mfc high in c+2.
REQ-030 A request arriving during ACCESS or DONE shall wait; no request shall be dropped.
REQ-031 A write shall never drive rdata.
REQ-032 mem_read and mem_write shall never be 1 simultaneously.
REQ-033 With FIXED_PRIO = 0 and both ports requesting continuously, grants shall alternate 0,1,0,1.

Reset
REQ-034 While reset = 0, the following shall clear immediately, independent of clock:
  - state = IDLE;
  - all outputs = 0, including rdata and grant;
  - timeout counter = 0;
  - last-granted = port 1, so port 0 wins the first tie.
REQ-035 Reset during ACCESS shall drop the strobes asynchronously and issue no mfc for the aborted access.
REQ-036 After reset release, the first grant shall occur no earlier than the first rising edge with reset = 1.

Verification
REQ-037 Port 0 read, addr 16'h0010, mem_rdata 16'hBEEF, mem_ready in the first ACCESS cycle -> mem_read and mem_addr 16'h0010 in c+1, mfc0 and rdata 16'hBEEF in c+2, err = 0.
REQ-038 Port 1 write, addr 16'h0100, wdata 16'h1234, mem_ready after 3 cycles -> mem_write held 3 cycles, one-cycle mfc1, rdata unchanged.
REQ-039 Both ports read continuously, FIXED_PRIO = 0, immediate ready -> grant sequence 01,10,01,10; with FIXED_PRIO = 1 -> port 0 granted every time.
REQ-040 Port 0 read, mem_ready never asserted, TIMEOUT = 15 -> mem_read high for 15 cycles, then mfc0 with err = 1 and rdata 16'hFFFF.
REQ-041 reset = 0 for one half-cycle mid-ACCESS -> strobes fall before the next edge, no mfc; a re-issued request then completes normally.
REQ-042 rd0 = wr0 = 1 -> read performed, mem_write stays 0.
